// File: rtl/sysmem_arbiter.sv
// sysmem_arbiter: shares four 1024x8 BRAM byte lanes between the CPU native
// memory port and the byte-wide loader port. Each access takes three cycles:
// grant in IDLE, one registered BRAM cycle in ACCESS, ready pulse in RESP.
module sysmem_arbiter #(
  parameter int AW = 10
) (
  input  logic          clka,
  input  logic          rsta,
  input  logic          boot_hold,
  input  logic          cpu_valid,
  input  logic [AW+1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic [3:0]    cpu_wstrb,
  output logic          cpu_ready,
  output logic [31:0]   cpu_rdata,
  input  logic          ld_valid,
  input  logic [AW+1:0] ld_addr,
  input  logic          ld_we,
  input  logic [7:0]    ld_wdata,
  output logic          ld_ready,
  output logic [7:0]    ld_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_ce,
  output logic [3:0]    mem_we,
  output logic [31:0]   mem_di,
  input  logic [31:0]   mem_do
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } stateType;

  stateType   state;
  stateType   stateNext;
  logic       cpuEligible;
  logic       ldEligible;
  logic       grantCpuNow;
  logic       grantLdNow;
  logic       lastGrantLd;
  logic       grantLd;
  logic [1:0] ldLane;
  logic [3:0] ldOneHot;
  logic [1:0] unusedCpuByteBits;

  assign cpuEligible       = cpu_valid & ~boot_hold;
  assign ldEligible        = ld_valid;
  assign ldOneHot          = 4'b0001 << ld_addr[1:0];
  assign unusedCpuByteBits = cpu_addr[1:0];

  // Next-state and round-robin grant decision; on a tie the side not granted last wins
  always_comb begin
    stateNext   = state;
    grantCpuNow = 1'b0;
    grantLdNow  = 1'b0;
    case (state)
      IDLE: begin
        if (ldEligible && (!cpuEligible || !lastGrantLd)) begin
          grantLdNow = 1'b1;
        end else if (cpuEligible) begin
          grantCpuNow = 1'b1;
        end
        if (grantLdNow || grantCpuNow) begin
          stateNext = ACCESS;
        end
      end
      ACCESS:  stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clka) begin
    if (rsta) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Registered BRAM drive, grant bookkeeping and ready pulses
  always_ff @(posedge clka) begin
    if (rsta) begin
      mem_addr    <= '0;
      mem_ce      <= 4'b0000;
      mem_we      <= 4'b0000;
      mem_di      <= 32'h0;
      cpu_ready   <= 1'b0;
      ld_ready    <= 1'b0;
      lastGrantLd <= 1'b0;
      grantLd     <= 1'b0;
      ldLane      <= 2'b00;
    end else begin
      mem_ce    <= 4'b0000;
      mem_we    <= 4'b0000;
      cpu_ready <= 1'b0;
      ld_ready  <= 1'b0;
      if (grantCpuNow) begin
        mem_addr    <= cpu_addr[AW+1:2];
        mem_ce      <= (cpu_wstrb == 4'b0000) ? 4'b1111 : cpu_wstrb;
        mem_we      <= cpu_wstrb;
        mem_di      <= cpu_wdata;
        grantLd     <= 1'b0;
        lastGrantLd <= 1'b0;
      end else if (grantLdNow) begin
        mem_addr    <= ld_addr[AW+1:2];
        mem_ce      <= ldOneHot;
        mem_we      <= ld_we ? ldOneHot : 4'b0000;
        mem_di      <= {4{ld_wdata}};
        grantLd     <= 1'b1;
        lastGrantLd <= 1'b1;
        ldLane      <= ld_addr[1:0];
      end
      if (state == ACCESS) begin
        cpu_ready <= ~grantLd;
        ld_ready  <= grantLd;
      end
    end
  end

  // BRAM output is only valid in the ready cycle, so read data passes straight through then
  always_comb begin
    cpu_rdata = 32'h0;
    ld_rdata  = 8'h00;
    if (cpu_ready) begin
      cpu_rdata = mem_do;
    end
    if (ld_ready) begin
      case (ldLane)
        2'd0:    ld_rdata = mem_do[7:0];
        2'd1:    ld_rdata = mem_do[15:8];
        2'd2:    ld_rdata = mem_do[23:16];
        default: ld_rdata = mem_do[31:24];
      endcase
    end
  end

endmodule

// File: doc/sysmem_arbiter.md
# sysmem_arbiter

Sequencer and two-port arbiter for the PicoRV32 system memory built from four 1024x8 single-port BRAM byte lanes (sysmem_mh). It shares the lanes between the CPU native memory interface (32-bit, byte strobes) and a byte-wide loader/debug port (UART boot loader). It drives the BRAM ce/we/address/data pins and hides the one-cycle unregistered BRAM read latency behind a valid/ready handshake on each side.

## Interface
Parameters:
- AW, 10, word-address width; BRAM depth = 2^AW

Ports:
- clka  in  1  system clock, shared with the BRAM clka
- rsta  in  1  synchronous active-high reset, same net as the BRAM rsta
- boot_hold  in  1  while 1, CPU requests are not granted
- cpu_valid  in  1  CPU request
- cpu_addr  in  AW+2  byte address; bits [AW+1:2] are used
- cpu_wdata  in  32  write data
- cpu_wstrb  in  4  byte strobes; 0 means read
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  32  read data, valid while cpu_ready=1
- ld_valid  in  1  loader request
- ld_addr  in  AW+2  byte address
- ld_we  in  1  1 = write byte, 0 = read byte
- ld_wdata  in  8  write byte
- ld_ready  out  1  one-cycle completion pulse
- ld_rdata  out  8  read byte, valid while ld_ready=1
- mem_addr  out  AW  shared address to all four lanes
- mem_ce  out  4  per-lane clock enable; lane i is bits [8i+7:8i]
- mem_we  out  4  per-lane write enable
- mem_di  out  32  lane write data
- mem_do  in  32  lane read data (BRAM doa, NOREG)

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any request is eligible, grant one, latch its address, data, strobes and the requester ID, then go to ACCESS.
  - A CPU request is eligible when cpu_valid=1 and boot_hold=0. A loader request is eligible when ld_valid=1.
- Arbitration is round-robin over the two requesters.
  - On a tie, the requester not granted last wins.
  - The last-grant register resets to CPU, so the loader wins the first tie after reset.
  - A sole eligible requester always wins.
- ACCESS: registered outputs drive the BRAM for exactly one cycle, then go to RESP.
  - CPU read: mem_ce=4'b1111, mem_we=0.
  - CPU write: mem_ce=mem_we=cpu_wstrb; mem_di=cpu_wdata.
  - Loader: mem_ce=mem_we-onehot(ld_addr[1:0]), with mem_we gated by ld_we; ld_wdata is replicated on all four lanes of mem_di.
  - mem_addr = addr[AW+1:2].
- RESP: pulse the granted side's ready for one cycle, then go to IDLE.
  - cpu_rdata = mem_do.
  - ld_rdata = lane of mem_do selected by the latched addr[1:0].
  - Write responses return the read-port contents; the value is undefined and must not be used.
- A request is captured at grant. Deasserting valid after grant does not cancel it; ready still pulses.
- Requesters must drop valid, or present a new request, in the cycle after ready. A valid still high in that cycle is treated as a new request.
- Outside ACCESS: mem_ce=0, mem_we=0. mem_addr and mem_di hold their last values.

## Timing
- Reset values: state=IDLE, cpu_ready=0, ld_ready=0, mem_ce=0, mem_we=0, mem_addr=0, mem_di=0, cpu_rdata=0, ld_rdata=0, last-grant=CPU.
- Latency: valid sampled in IDLE at cycle T, mem_ce high at T+1, ready at T+2, next grant possible at T+3.
- Throughput: one access per 3 cycles.
- Read data is driven from mem_do during the ready cycle; the BRAM output is valid in the cycle after its ce edge.
- rsta mid-operation:
  - Next cycle: IDLE, no ready pulse, mem_ce=0.
  - A write whose ACCESS cycle coincides with rsta still commits at that edge, because the BRAM write is not reset-gated.
  - The pending transaction is dropped, so the requester must reissue it.
- boot_hold rising while a CPU access is in flight: that access completes. Only new grants are blocked.
- boot_hold=1 with only the CPU requesting: stays in IDLE with no BRAM activity.
- Address wrap: addresses above 2^AW words alias modulo the depth; no error is reported.

## Test plan
- Reset, then CPU write 0xDEADBEEF strobe 4'hF at word 5, then read word 5 -> cpu_ready exactly 2 cycles after each grant; cpu_rdata=0xDEADBEEF; mem_ce=4'hF only in the ACCESS cycles.
- CPU strobe 4'b0100 write of 0x00AA0000 over 0x11223344 at word 7 -> read returns 0x11AA3344; mem_we=4'b0100 during the write.
- Loader writes bytes 0x01..0x04 to byte addresses 0x10..0x13, then CPU reads word 4 -> 0x04030201; each loader access shows a one-hot mem_ce.
- cpu_valid and ld_valid both held high for 12 cycles -> grants alternate loader, CPU, loader, CPU; each ready is 2 cycles after its grant; no double grants.
- boot_hold=1 with both requesting -> only loader grants; the CPU waits until boot_hold falls, then is granted in the next IDLE cycle.
- rsta asserted during the ACCESS cycle of a CPU write of 0x55 at word 9 -> no cpu_ready; all outputs return to reset values the next cycle; a subsequent read of word 9 returns 0x55.
